// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory freeze > redirect > load-use.
// Define PIPE_HAZARD_PERF_EN to build the saturating stall/redirect counters.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_bubble,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             mem_timeout,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_ERROR    = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_V    = 8'(MEM_TIMEOUT);
    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [1:0] flush_rem_q, flush_rem_d;

    logic freeze, loaduse;
    logic pc_en_c, if_id_en_c, if_id_flush_c, id_ex_en_c, id_ex_bubble_c;
    logic ex_mem_en_c, mem_wb_en_c, mem_timeout_c;

    always_comb begin
        freeze  = mem_req & ~mem_ack;
        loaduse = ex_memread & (ex_rd != 5'd0) &
                  ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        flush_rem_d    = flush_rem_q;
        pc_en_c        = 1'b0;
        if_id_en_c     = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_en_c     = 1'b0;
        id_ex_bubble_c = 1'b0;
        ex_mem_en_c    = 1'b0;
        mem_wb_en_c    = 1'b0;
        mem_timeout_c  = 1'b0;

        if (state_q == ST_ERROR) begin
            mem_timeout_c = 1'b1;
        end else if (freeze) begin
            // Whole pipeline holds; the wait counter measures how long memory has stalled.
            if (state_q == ST_MEM_WAIT) begin
                if (wait_cnt_q == TIMEOUT_V) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end else begin
                state_d    = ST_MEM_WAIT;
                wait_cnt_d = 8'd1;
            end
        end else begin
            pc_en_c     = 1'b1;
            if_id_en_c  = 1'b1;
            id_ex_en_c  = 1'b1;
            ex_mem_en_c = 1'b1;
            mem_wb_en_c = 1'b1;
            wait_cnt_d  = 8'd0;
            if (ex_redirect) begin
                if_id_flush_c  = 1'b1;
                id_ex_bubble_c = 1'b1;
                flush_rem_d    = FLUSH_RELOAD;
                state_d        = (FLUSH_RELOAD != 2'd0) ? ST_FLUSH : ST_RUN;
            end else if (state_q == ST_FLUSH) begin
                // Wrong-path fetch slots are still draining, so a load-use match is moot.
                if_id_flush_c = 1'b1;
                flush_rem_d   = flush_rem_q - 2'd1;
                if (flush_rem_q <= 2'd1) begin
                    state_d = ST_RUN;
                end
            end else begin
                state_d = ST_RUN;
                if (loaduse) begin
                    pc_en_c        = 1'b0;
                    if_id_en_c     = 1'b0;
                    id_ex_bubble_c = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= 8'd0;
            flush_rem_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            flush_rem_q <= flush_rem_d;
        end
    end

    // Outputs are forced quiet while reset is held, independent of the flop contents.
    assign pc_en        = arst_n & pc_en_c;
    assign if_id_en     = arst_n & if_id_en_c;
    assign if_id_flush  = arst_n & if_id_flush_c;
    assign id_ex_en     = arst_n & id_ex_en_c;
    assign id_ex_bubble = arst_n & id_ex_bubble_c;
    assign ex_mem_en    = arst_n & ex_mem_en_c;
    assign mem_wb_en    = arst_n & mem_wb_en_c;
    assign mem_timeout  = arst_n & mem_timeout_c;
    assign state        = arst_n ? state_q : ST_RUN;

`ifdef PIPE_HAZARD_PERF_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             redirect_acc, stall_cyc;

    assign redirect_acc = ex_redirect & ~freeze & (state_q != ST_ERROR);
    assign stall_cyc    = ~pc_en_c & (state_q != ST_ERROR);

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_cyc) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
            if (redirect_acc) begin
                flush_cnt_q <= sat_inc(flush_cnt_q);
            end
        end
    end

    assign stall_cnt = arst_n ? stall_cnt_q : '0;
    assign flush_cnt = arst_n ? flush_cnt_q : '0;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with FLUSH_CYCLES=3, MEM_TIMEOUT=4.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Packed control view: {pc,ifid,flush,idex,bubble,exmem,memwb,timeout}
    localparam logic [7:0] C_OFF  = 8'h00;
    localparam logic [7:0] C_NORM = 8'hD6;
    localparam logic [7:0] C_LU   = 8'h1E;
    localparam logic [7:0] C_RED  = 8'hFE;
    localparam logic [7:0] C_FLS  = 8'hF6;
    localparam logic [7:0] C_ERR  = 8'h01;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        ex_memread, id_uses_rs2, ex_redirect, mem_req, mem_ack;
    logic [4:0]  ex_rd, id_rs1, id_rs2;
    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble;
    logic        ex_mem_en, mem_wb_en, mem_timeout;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .arst_n(arst_n),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .mem_timeout(mem_timeout),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [7:0] ctl();
        return {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
                ex_mem_en, mem_wb_en, mem_timeout};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_memread = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0;
        ex_redirect = 0; mem_req = 0; mem_ack = 0;
    endtask

    task automatic test_reset();
        arst_n = 0;
        idle_inputs();
        tick(); tick();
        total++; if (ctl() !== C_OFF) begin bad++; $display("FAIL reset_ctl got=%h want=%h", ctl(), C_OFF); end
        total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
        total++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", stall_cnt, flush_cnt); end
        arst_n = 1;
        #1;
        total++; if (ctl() !== C_NORM) begin bad++; $display("FAIL post_reset_ctl got=%h want=%h", ctl(), C_NORM); end
        tick();
    endtask

    task automatic test_loaduse();
        ex_memread = 1; ex_rd = 5; id_rs1 = 5;
        #1;
        total++; if (ctl() !== C_LU) begin bad++; $display("FAIL lu_rs1_ctl got=%h want=%h", ctl(), C_LU); end
        total++; if (state !== 2'd0) begin bad++; $display("FAIL lu_rs1_state got=%0d want=0", state); end
        tick(); exp_stall++;
        idle_inputs();
        #1;
        total++; if (ctl() !== C_NORM || state !== 2'd0) begin bad++; $display("FAIL lu_release got=%h/%0d want=%h/0", ctl(), state, C_NORM); end
        total++; if (stall_cnt !== 16'(PERF ? exp_stall : 0)) begin bad++; $display("FAIL lu_stall_cnt got=%0d want=%0d", stall_cnt, PERF ? exp_stall : 0); end
        // rs2 match counts only when the instruction reads rs2
        ex_memread = 1; ex_rd = 7; id_rs1 = 3; id_rs2 = 7; id_uses_rs2 = 1;
        #1;
        total++; if (ctl() !== C_LU) begin bad++; $display("FAIL lu_rs2_ctl got=%h want=%h", ctl(), C_LU); end
        tick(); exp_stall++;
        id_uses_rs2 = 0;
        #1;
        total++; if (ctl() !== C_NORM) begin bad++; $display("FAIL lu_rs2_unused got=%h want=%h", ctl(), C_NORM); end
        ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        #1;
        total++; if (ctl() !== C_NORM) begin bad++; $display("FAIL lu_x0 got=%h want=%h", ctl(), C_NORM); end
        ex_memread = 0; ex_rd = 4; id_rs1 = 4;
        #1;
        total++; if (ctl() !== C_NORM) begin bad++; $display("FAIL lu_noload got=%h want=%h", ctl(), C_NORM); end
        tick();
        idle_inputs();
    endtask

    task automatic test_redirect();
        logic [1:0] exp_st [4];
        logic [7:0] exp_c  [4];
        exp_st[0] = 2'd0; exp_st[1] = 2'd2; exp_st[2] = 2'd2; exp_st[3] = 2'd0;
        exp_c[0] = C_RED; exp_c[1] = C_FLS; exp_c[2] = C_FLS; exp_c[3] = C_NORM;
        for (int i = 0; i < 4; i++) begin
            ex_redirect = (i == 0);
            #1;
            total++; if (ctl() !== exp_c[i] || state !== exp_st[i]) begin bad++; $display("FAIL redir_c%0d got=%h/%0d want=%h/%0d", i, ctl(), state, exp_c[i], exp_st[i]); end
            tick();
            if (i == 0) exp_flush++;
        end
        total++; if (flush_cnt !== 16'(PERF ? exp_flush : 0)) begin bad++; $display("FAIL redir_flush_cnt got=%0d want=%0d", flush_cnt, PERF ? exp_flush : 0); end
    endtask

    task automatic test_redirect_priority();
        // Redirect beats load-use, then a second redirect in FLUSH restarts the drain
        ex_redirect = 1; ex_memread = 1; ex_rd = 9; id_rs1 = 9;
        #1;
        total++; if (ctl() !== C_RED) begin bad++; $display("FAIL prio_redir_lu got=%h want=%h", ctl(), C_RED); end
        tick(); exp_flush++;
        ex_memread = 0;
        #1;
        total++; if (ctl() !== C_RED || state !== 2'd2) begin bad++; $display("FAIL prio_restart got=%h/%0d want=%h/2", ctl(), state, C_RED); end
        tick(); exp_flush++;
        ex_redirect = 0; ex_memread = 1;
        #1;
        total++; if (ctl() !== C_FLS || state !== 2'd2) begin bad++; $display("FAIL flush_ignores_lu got=%h/%0d want=%h/2", ctl(), state, C_FLS); end
        tick();
        ex_memread = 0;
        #1;
        total++; if (ctl() !== C_FLS || state !== 2'd2) begin bad++; $display("FAIL restart_tail got=%h/%0d want=%h/2", ctl(), state, C_FLS); end
        tick();
        #1;
        total++; if (ctl() !== C_NORM || state !== 2'd0) begin bad++; $display("FAIL restart_done got=%h/%0d want=%h/0", ctl(), state, C_NORM); end
        total++; if (flush_cnt !== 16'(PERF ? exp_flush : 0)) begin bad++; $display("FAIL prio_flush_cnt got=%0d want=%0d", flush_cnt, PERF ? exp_flush : 0); end
        idle_inputs();
    endtask

    task automatic test_mem_wait();
        mem_req = 1; mem_ack = 1;
        #1;
        total++; if (ctl() !== C_NORM) begin bad++; $display("FAIL mem_ack_nostall got=%h want=%h", ctl(), C_NORM); end
        tick();
        total++; if (state !== 2'd0) begin bad++; $display("FAIL mem_ack_state got=%0d want=0", state); end
        mem_ack = 0;
        for (int i = 0; i < 3; i++) begin
            ex_redirect = (i > 0);
            #1;
            total++; if (ctl() !== C_OFF || state !== ((i == 0) ? 2'd0 : 2'd1)) begin bad++; $display("FAIL mem_freeze_c%0d got=%h/%0d want=%h/%0d", i, ctl(), state, C_OFF, (i == 0) ? 0 : 1); end
            tick(); exp_stall++;
        end
        mem_ack = 1;
        #1;
        total++; if (ctl() !== C_RED || state !== 2'd1) begin bad++; $display("FAIL mem_ack_redir got=%h/%0d want=%h/1", ctl(), state, C_RED); end
        tick(); exp_flush++;
        idle_inputs();
        #1;
        total++; if (ctl() !== C_FLS || state !== 2'd2) begin bad++; $display("FAIL mem_after_ack got=%h/%0d want=%h/2", ctl(), state, C_FLS); end
        tick(); tick();
        #1;
        total++; if (ctl() !== C_NORM || state !== 2'd0) begin bad++; $display("FAIL mem_back_run got=%h/%0d want=%h/0", ctl(), state, C_NORM); end
        total++; if (stall_cnt !== 16'(PERF ? exp_stall : 0) || flush_cnt !== 16'(PERF ? exp_flush : 0)) begin bad++; $display("FAIL mem_cnts got=%0d/%0d want=%0d/%0d", stall_cnt, flush_cnt, PERF ? exp_stall : 0, PERF ? exp_flush : 0); end
    endtask

    task automatic test_timeout();
        mem_req = 1; mem_ack = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (ctl() !== C_OFF || state !== ((i == 0) ? 2'd0 : 2'd1)) begin bad++; $display("FAIL to_freeze_c%0d got=%h/%0d want=%h/%0d", i, ctl(), state, C_OFF, (i == 0) ? 0 : 1); end
            tick(); exp_stall++;
        end
        for (int i = 0; i < 20; i++) begin
            mem_req = (i < 10);
            ex_redirect = (i == 5);
            #1;
            total++; if (ctl() !== C_ERR || state !== 2'd3) begin bad++; $display("FAIL to_error_c%0d got=%h/%0d want=%h/3", i, ctl(), state, C_ERR); end
            tick();
        end
        total++; if (stall_cnt !== 16'(PERF ? exp_stall : 0) || flush_cnt !== 16'(PERF ? exp_flush : 0)) begin bad++; $display("FAIL to_cnts got=%0d/%0d want=%0d/%0d", stall_cnt, flush_cnt, PERF ? exp_stall : 0, PERF ? exp_flush : 0); end
        idle_inputs();
        arst_n = 0;
        #1;
        total++; if (ctl() !== C_OFF || state !== 2'd0) begin bad++; $display("FAIL to_in_reset got=%h/%0d want=%h/0", ctl(), state, C_OFF); end
        tick();
        arst_n = 1;
        #1;
        total++; if (ctl() !== C_NORM || state !== 2'd0) begin bad++; $display("FAIL to_recover got=%h/%0d want=%h/0", ctl(), state, C_NORM); end
        total++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin bad++; $display("FAIL to_cnt_clear got=%0d/%0d want=0/0", stall_cnt, flush_cnt); end
        tick();
    endtask

    initial begin
        test_reset();
        test_loaduse();
        test_redirect();
        test_redirect_priority();
        test_mem_wait();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
